// File: rtl/slt_serial_ctrl_if.sv
// Request/response bundle between the execute stage and the serial
// set-less-than sequencer.
interface slt_serial_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;
   logic [WIDTH-1:0] result;

   modport master (
      output start, signed_op, rs, rt,
      input  busy, done, lt, eq, gt, result
   );

   modport slave (
      input  start, signed_op, rs, rt,
      output busy, done, lt, eq, gt, result
   );
endinterface

// File: rtl/slt_serial_ctrl.sv
// Serial slt/sltu sequencer: walks a 1-bit lt/eq/gt compare stage across the
// captured operands LSB first and returns the relation flags and 0/1 word.
module slt_serial_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   slt_serial_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
   localparam logic [2:0]       CHAIN_SEED = 3'b010;

   // One compare-stage step; chain vectors are packed {lt, eq, gt}.
   function automatic logic [2:0] chain_step(
      input logic       a,
      input logic       b,
      input logic [2:0] c
   );
      logic same;
      same = ~(a ^ b);
      chain_step[2] = (b & ~a) | (same & c[2]);
      chain_step[1] = c[1] & same;
      chain_step[0] = (a & ~b) | (same & c[0]);
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opa_nxt_s;
   logic [WIDTH-1:0] opb_r;
   logic [WIDTH-1:0] opb_nxt_s;
   logic             sgn_r;
   logic             sgn_nxt_s;
   logic [2:0]       chain_r;
   logic [2:0]       chain_nxt_s;
   logic [2:0]       flags_r;
   logic [2:0]       flags_nxt_s;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] result_nxt_s;
   logic             busy_r;
   logic             done_r;
   logic             last_s;
   logic             swap_s;
   logic             bit_a_s;
   logic             bit_b_s;
   logic [2:0]       step_s;

   // Next-state, datapath and output-register load decisions.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      opa_nxt_s    = opa_r;
      opb_nxt_s    = opb_r;
      sgn_nxt_s    = sgn_r;
      chain_nxt_s  = chain_r;
      flags_nxt_s  = flags_r;
      result_nxt_s = result_r;

      last_s  = (cnt_r == LAST_IDX);
      // The sign bit carries negative weight, so its comparison flips.
      swap_s  = sgn_r & last_s;
      bit_a_s = swap_s ? opb_r[cnt_r] : opa_r[cnt_r];
      bit_b_s = swap_s ? opa_r[cnt_r] : opb_r[cnt_r];
      step_s  = chain_step(bit_a_s, bit_b_s, chain_r);

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_RUN;
               opa_nxt_s   = bus.rs;
               opb_nxt_s   = bus.rt;
               sgn_nxt_s   = bus.signed_op;
               cnt_nxt_s   = {CNT_W{1'b0}};
               chain_nxt_s = CHAIN_SEED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            chain_nxt_s = step_s;
            if (last_s) begin
               state_nxt_s  = ST_DONE;
               flags_nxt_s  = step_s;
               result_nxt_s = {{(WIDTH-1){1'b0}}, step_s[2]};
            end else begin
               cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, operand, chain and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         opa_r    <= {WIDTH{1'b0}};
         opb_r    <= {WIDTH{1'b0}};
         sgn_r    <= 1'b0;
         chain_r  <= CHAIN_SEED;
         flags_r  <= 3'b000;
         result_r <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         opa_r    <= opa_nxt_s;
         opb_r    <= opb_nxt_s;
         sgn_r    <= sgn_nxt_s;
         chain_r  <= chain_nxt_s;
         flags_r  <= flags_nxt_s;
         result_r <= result_nxt_s;
         busy_r   <= (state_nxt_s == ST_RUN);
         done_r   <= (state_nxt_s == ST_DONE);
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.lt     = flags_r[2];
   assign bus.eq     = flags_r[1];
   assign bus.gt     = flags_r[0];
   assign bus.result = result_r;

endmodule

// File: doc/slt_serial_ctrl.md
# slt_serial_ctrl

Multi-cycle sequencer for the MIPS set-less-than path. It captures two operands and walks a single-bit lt/eq/gt compare stage across them, one bit per clock, LSB first. The stage's chain inputs are fed back from its own registered outputs. The block handles both `slt` (signed) and `sltu` (unsigned), and returns the 0/1 result word plus the three relation flags to the execute stage through a start/busy/done handshake.

## Interface

**Parameters**
- `WIDTH`, default 32: operand width in bits; must be ≥ 2.
- `CNT_W`, default 5: bit-index counter width; must be ≥ ceil(log2(WIDTH)).

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a compare; sampled only in IDLE.
- `signed_op` input 1: 1 = `slt` (two's complement), 0 = `sltu`; captured with the operands.
- `rs` input WIDTH: operand A, captured on start acceptance.
- `rt` input WIDTH: operand B, captured on start acceptance.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE; results are valid from this cycle on.
- `lt` output 1: A < B for the last completed operation.
- `eq` output 1: A == B for the last completed operation.
- `gt` output 1: A > B for the last completed operation.
- `result` output WIDTH: {WIDTH-1 zeros, lt}, i.e. the slt/sltu writeback value.

## Operation

**States**
- IDLE: wait for a request.
  - `start`=1 → RUN.
  - Same edge: latch `rs`, `rt`, `signed_op` into internal registers; set bit counter = 0; seed the chain lt_c=0, eq_c=1, gt_c=0.
- RUN: one bit per edge, at index i = counter.
  - Bit pair: a = A[i], b = B[i].
  - Signed MSB swap: if `signed_op`=1 and i = WIDTH-1, swap a and b (the sign bit has inverted weight).
  - Chain update:
    - lt_c ← (b & ~a) | (~(a^b) & lt_c)
    - eq_c ← eq_c & ~(a^b)
    - gt_c ← (a & ~b) | (~(a^b) & gt_c)
  - i < WIDTH-1: counter increments, stay in RUN.
  - i = WIDTH-1: next state DONE. Same edge: `lt`/`eq`/`gt`/`result` registers load the final chain values.
- DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
  - `start` in DONE is ignored.

**Rules**
- Output registers `lt`/`eq`/`gt`/`result` change only on the RUN→DONE edge or on reset. They hold their values through the following IDLE period and through the whole of the next RUN.
- Exactly one of `lt`, `eq`, `gt` is 1 after any completed operation.
- Operand or `signed_op` changes after acceptance have no effect.
- `start` in RUN or DONE is ignored; there is no queueing.
- Counter never exceeds WIDTH-1; no wrap-around occurs inside RUN.

## Timing

- Reset (`rst_n`=0, asynchronous):
  - State = IDLE, counter = 0, internal operands = 0.
  - `busy`=0, `done`=0, `lt`=0, `eq`=0, `gt`=0, `result`=0.
  - Takes effect immediately, including mid-RUN; the in-flight operation is discarded with no `done`.
- Start accepted at edge E0.
  - `busy`=1 from after E0 until after edge E_WIDTH.
  - Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
  - `done`=1 and valid results in the cycle after E_WIDTH.
  - `done` drops after E_WIDTH+1.
- Latency: WIDTH+1 edges from acceptance to the `done` cycle.
- Throughput: one operation per WIDTH+2 cycles with `start` held high. The next acceptance happens at the first edge after returning to IDLE.
- `busy` and `done` are mutually exclusive and both are registered (state decode only).

## Test plan

1. Unsigned less-than: WIDTH=32, `rs`=5, `rt`=9, `signed_op`=0, 1-cycle `start` → `done` exactly 33 edges later; `lt`=1, `eq`=0, `gt`=0, `result`=0x00000001.
2. Sign handling, same operands `rs`=0xFFFFFFFF, `rt`=0x00000001:
   - `signed_op`=1 → `lt`=1, `result`=1.
   - `signed_op`=0 → `gt`=1, `result`=0.
3. Equality and MSB edge: `rs`=`rt`=0x80000000, signed and unsigned → `eq`=1, `result`=0.
   - Separately, `rs`=0x80000000, `rt`=0x7FFFFFFF, signed → `lt`=1.
4. Operand isolation: accept `rs`=3, `rt`=2. Mid-RUN, change to `rs`=0, `rt`=0xFFFFFFFF and pulse `start` → `gt`=1. Only one `done` pulse; `busy` never drops early.
5. Reset mid-operation: assert `rst_n`=0 at RUN bit 10 → all outputs 0 immediately, no `done`. After release, `rs`=1, `rt`=1 completes normally with `eq`=1 after 33 edges.
6. Back-to-back: `start` held at 1 with a fixed operand pair (7 vs 7) → `done` pulses every 34 cycles. `lt`/`eq`/`gt` stay stable between pulses.
